// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences one multi-byte SPI transaction (command, optional
// address, write data, optional dummy, read data) through a single-byte
// spi_master, holding chip select across the whole byte sequence.
// Build option: define SPI_XFER_CTRL_DUMMY_EN to add the dummy_len input and
// the DUMMY phase; without it the DUMMY phase is always skipped.
module spi_xfer_ctrl #(
  parameter int                DWIDTH     = 8,
  parameter int                ADDR_BYTES = 3,
  parameter int                LEN_WIDTH  = 8,
  parameter logic [DWIDTH-1:0] FILL       = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DWIDTH-1:0]            cmd,
  input  logic                         addr_en,
  input  logic [DWIDTH*ADDR_BYTES-1:0] addr,
  input  logic [LEN_WIDTH-1:0]         wr_len,
  input  logic [LEN_WIDTH-1:0]         rd_len,
`ifdef SPI_XFER_CTRL_DUMMY_EN
  input  logic [3:0]                   dummy_len,
`endif
  input  logic [DWIDTH-1:0]            wdata,
  input  logic                         wdata_valid,
  output logic                         wdata_ready,
  output logic [DWIDTH-1:0]            rdata,
  output logic                         rdata_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         cs,
  output logic                         m_send,
  output logic                         m_receive,
  output logic [DWIDTH-1:0]            m_din,
  output logic [DWIDTH-1:0]            m_din_nonsend,
  input  logic [DWIDTH-1:0]            m_dout,
  input  logic                         m_rvld,
  input  logic                         m_idle
);

  localparam int AW    = DWIDTH * ADDR_BYTES;
  localparam int AB_W  = $clog2(ADDR_BYTES + 1);
  localparam int MAX_W = (LEN_WIDTH > AB_W) ? LEN_WIDTH : AB_W;
  localparam int CNT_W = (MAX_W > 4) ? MAX_W : 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {PH_CMD, PH_ADDR, PH_WR, PH_DUMMY, PH_RD} phase_t;

  state_t             state, state_n;
  phase_t             phase, adv_phase;
  logic [CNT_W-1:0]   cnt, adv_cnt;
  logic               adv_ok;
  logic               last_byte;

  logic [DWIDTH-1:0]    cmd_q;
  logic [AW-1:0]        addr_q;
  logic                 addr_en_q;
  logic [LEN_WIDTH-1:0] wr_len_q;
  logic [LEN_WIDTH-1:0] rd_len_q;
  logic [3:0]           dum_len_q;

  assign m_din_nonsend = FILL;
  assign last_byte     = (cnt == CNT_W'(1));

  // Next non-empty phase after the current one, with its byte count.
  always_comb begin
    adv_ok    = 1'b0;
    adv_phase = phase;
    adv_cnt   = '0;
    if (phase == PH_CMD && addr_en_q) begin
      adv_ok    = 1'b1;
      adv_phase = PH_ADDR;
      adv_cnt   = CNT_W'(ADDR_BYTES);
    end else if ((phase == PH_CMD || phase == PH_ADDR) && wr_len_q != '0) begin
      adv_ok    = 1'b1;
      adv_phase = PH_WR;
      adv_cnt   = CNT_W'(wr_len_q);
    end else if ((phase == PH_CMD || phase == PH_ADDR || phase == PH_WR) &&
                 dum_len_q != '0) begin
      adv_ok    = 1'b1;
      adv_phase = PH_DUMMY;
      adv_cnt   = CNT_W'(dum_len_q);
    end else if (phase != PH_RD && rd_len_q != '0) begin
      adv_ok    = 1'b1;
      adv_phase = PH_RD;
      adv_cnt   = CNT_W'(rd_len_q);
    end
  end

  // FSM next state and the single-cycle strobes towards spi_master.
  always_comb begin
    state_n     = state;
    m_send      = 1'b0;
    m_receive   = 1'b0;
    m_din       = '0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        case (phase)
          PH_CMD:  m_din = cmd_q;
          PH_ADDR: m_din = addr_q[AW-1 -: DWIDTH];
          PH_WR:   m_din = wdata;
          default: m_din = '0;
        endcase
        if (m_idle) begin
          if (phase == PH_DUMMY || phase == PH_RD) begin
            m_receive = 1'b1;
            state_n   = S_WAIT;
          end else if (phase != PH_WR || wdata_valid) begin
            m_send      = 1'b1;
            wdata_ready = (phase == PH_WR);
            state_n     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (m_rvld) state_n = (!last_byte || adv_ok) ? S_ISSUE : S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Nothing is launched towards spi_master while reset is applied.
    if (rst) begin
      m_send      = 1'b0;
      m_receive   = 1'b0;
      m_din       = '0;
      wdata_ready = 1'b0;
      done        = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Control registers: phase walk, byte counter, busy/cs and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_CMD;
      cnt         <= '0;
      busy        <= 1'b0;
      cs          <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cs    <= 1'b1;
            phase <= PH_CMD;
            cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (m_rvld) begin
            if (phase == PH_RD) begin
              rdata       <= m_dout;
              rdata_valid <= 1'b1;
            end
            if (!last_byte) begin
              cnt <= cnt - CNT_W'(1);
            end else if (adv_ok) begin
              phase <= adv_phase;
              cnt   <= adv_cnt;
            end
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          cs   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Transaction fields captured at start; address shifts out MSB byte first.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cmd_q     <= cmd;
      addr_q    <= addr;
      addr_en_q <= addr_en;
      wr_len_q  <= wr_len;
      rd_len_q  <= rd_len;
`ifdef SPI_XFER_CTRL_DUMMY_EN
      dum_len_q <= dummy_len;
`else
      dum_len_q <= '0;
`endif
    end else if (state == S_WAIT && m_rvld && phase == PH_ADDR) begin
      addr_q <= addr_q << DWIDTH;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with a bench-side spi_master model.
// Build option SPI_XFER_CTRL_DUMMY_EN enables the dummy-phase test.
module tb_spi_xfer_ctrl;
  localparam int AB = 3;
  localparam logic [7:0] FILLB = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, addr_en, wdata_valid, wdata_ready, rdata_valid;
  logic        busy, done, cs, m_send, m_receive, m_rvld, m_idle;
  logic [7:0]  cmd, wr_len, rd_len, wdata, rdata, m_din, m_din_nonsend, m_dout;
  logic [23:0] addr;
`ifdef SPI_XFER_CTRL_DUMMY_EN
  logic [3:0]  dummy_len;
`endif

  spi_xfer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr_en(addr_en),
    .addr(addr), .wr_len(wr_len), .rd_len(rd_len),
`ifdef SPI_XFER_CTRL_DUMMY_EN
    .dummy_len(dummy_len),
`endif
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .cs(cs), .m_send(m_send), .m_receive(m_receive), .m_din(m_din),
    .m_din_nonsend(m_din_nonsend), .m_dout(m_dout), .m_rvld(m_rvld),
    .m_idle(m_idle)
  );

  int vectors = 0;
  int miscompares = 0;

  // transaction model: byte plan of the current transaction
  bit         checking, model_busy, pend, exp_done, exp_rv, saw_done;
  logic [7:0] exp_rdata;
  int         k, inflight, total, nsend, wr_lo, wr_hi, rd_lo, sl_cnt;
  logic [7:0] exp_mosi [0:1023];
  logic [7:0] resp [0:1023];
  logic [7:0] wq [0:4095];
  int         widx, wv_pct, stall_idx, stall_left;
  logic [7:0] rd_pre [$];

  // observation logs
  logic [7:0] mosi_log [$];
  logic [7:0] rdata_log [$];
  int         wr_pulses, done_cnt, rv_cnt, bad_cs;

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Build the byte plan for a newly accepted transaction.
  task automatic accept();
    int ae, wl, rl, dm;
    ae = int'(addr_en);
    wl = int'(wr_len);
    rl = int'(rd_len);
`ifdef SPI_XFER_CTRL_DUMMY_EN
    dm = int'(dummy_len);
`else
    dm = 0;
`endif
    nsend = 1 + ae * AB + wl;
    wr_lo = 1 + ae * AB;
    wr_hi = nsend;
    rd_lo = nsend + dm;
    total = rd_lo + rl;
    exp_mosi[0] = cmd;
    for (int a = 0; a < ae * AB; a++) exp_mosi[1 + a] = 8'(addr >> (8 * (AB - 1 - a)));
    for (int j = 0; j < wl; j++) exp_mosi[wr_lo + j] = wq[(widx + j) % 4096];
    for (int j = 0; j < total; j++) resp[j] = 8'($urandom);
    for (int j = 0; j < rl; j++) if (j < rd_pre.size()) resp[rd_lo + j] = rd_pre[j];
    k = 0;
    pend = 1'b1;
    model_busy = 1'b1;
  endtask

  // Compare DUT outputs with the model, then advance the model one cycle.
  task automatic sample();
    bit wrb, es, dn, nrv;
    wrb = (k >= wr_lo) && (k < wr_hi);
    es  = !rst && model_busy && pend && (sl_cnt == 0) && (!wrb || wdata_valid);
    dn  = exp_done;
    if (checking) begin
      chk1("busy", busy, model_busy);
      chk1("cs", cs, model_busy);
      chk1("done", done, dn && !rst);
      chk1("rdata_valid", rdata_valid, exp_rv);
      chk8("rdata", rdata, exp_rdata);
      chk8("m_din_nonsend", m_din_nonsend, FILLB);
      chk1("m_send", m_send, es && (k < nsend));
      chk1("m_receive", m_receive, es && (k >= nsend));
      chk1("wdata_ready", wdata_ready, es && wrb);
      if (es && k < nsend) chk8("m_din", m_din, exp_mosi[k]);
      if (m_send) mosi_log.push_back(m_din);
      if (m_receive) mosi_log.push_back(m_din_nonsend);
      if ((m_send || m_receive) && !cs) bad_cs++;
      if (wdata_ready) wr_pulses++;
      if (done) begin done_cnt++; saw_done = 1'b1; end
      if (rdata_valid) begin rdata_log.push_back(rdata); rv_cnt++; end
    end
    if (rst) begin
      model_busy = 1'b0; pend = 1'b0; sl_cnt = 0;
      exp_rv = 1'b0; exp_rdata = 8'h00; exp_done = 1'b0;
    end else begin
      nrv = 1'b0;
      if (es) begin
        if (wrb) widx = (widx + 1) % 4096;
        inflight = k;
        k++;
        pend = 1'b0;
        sl_cnt = $urandom_range(2, 6);
      end else if (sl_cnt > 0) begin
        if (sl_cnt == 1) begin
          if (inflight >= rd_lo) begin nrv = 1'b1; exp_rdata = resp[inflight]; end
          if (k < total) pend = 1'b1;
          else exp_done = 1'b1;
        end
        sl_cnt--;
      end
      if (dn) begin
        model_busy = 1'b0;
        exp_done = 1'b0;
      end else if (!model_busy && start) begin
        accept();
      end
      exp_rv = nrv;
    end
  endtask

  // Bench spi_master and write-stream source.
  task automatic drive();
    m_idle = (sl_cnt == 0);
    m_rvld = (sl_cnt == 1);
    m_dout = (sl_cnt == 1) ? resp[inflight] : 8'($urandom);
    wdata  = wq[widx];
    if (pend && sl_cnt == 0 && k >= wr_lo && k < wr_hi && widx == stall_idx && stall_left > 0) begin
      wdata_valid = 1'b0;
      stall_left--;
    end else begin
      wdata_valid = ($urandom_range(99) < wv_pct);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    mosi_log.delete(); rdata_log.delete();
    wr_pulses = 0; done_cnt = 0; rv_cnt = 0; bad_cs = 0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!saw_done && n < limit) begin tick(); n++; end
    chk1("txn_completes", saw_done, 1'b1);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic ae, input logic [23:0] a,
                         input logic [7:0] wl, input logic [7:0] rl);
    cmd = c; addr_en = ae; addr = a; wr_len = wl; rd_len = rl;
    clear_logs();
    saw_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) wq[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; cmd = 8'h00; addr_en = 1'b0; addr = 24'h0;
    wr_len = 8'h00; rd_len = 8'h00;
`ifdef SPI_XFER_CTRL_DUMMY_EN
    dummy_len = 4'h0;
`endif
    checking = 1'b0; model_busy = 1'b0; pend = 1'b0; exp_done = 1'b0; exp_rv = 1'b0;
    exp_rdata = 8'h00; saw_done = 1'b0; k = 0; inflight = 0; total = 0; nsend = 0;
    wr_lo = 0; wr_hi = 0; rd_lo = 0; sl_cnt = 0; widx = 0; wv_pct = 100;
    stall_idx = -1; stall_left = 0;
    clear_logs();
    drive();
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_cs", cs, 1'b0);
    chk8("reset_rdata", rdata, 8'h00);
    chk8("reset_fill", m_din_nonsend, 8'hFF);

    // single command byte
    run_txn(8'h06, 1'b0, 24'h0, 8'd0, 8'd0);
    chki("wren_bytes", mosi_log.size(), 1);
    chk8("wren_byte0", mosi_log[0], 8'h06);
    chki("wren_done_pulses", done_cnt, 1);
    chki("wren_cs_low_on_strobe", bad_cs, 0);

    // read with address
    rd_pre.delete(); rd_pre.push_back(8'hA5); rd_pre.push_back(8'h5A);
    wv_pct = 60;
    run_txn(8'h03, 1'b1, 24'h123456, 8'd0, 8'd2);
    rd_pre.delete();
    chki("read_bytes", mosi_log.size(), 6);
    chk8("read_mosi0", mosi_log[0], 8'h03);
    chk8("read_mosi1", mosi_log[1], 8'h12);
    chk8("read_mosi2", mosi_log[2], 8'h34);
    chk8("read_mosi3", mosi_log[3], 8'h56);
    chk8("read_mosi4", mosi_log[4], 8'hFF);
    chk8("read_mosi5", mosi_log[5], 8'hFF);
    chki("read_rv_cnt", rv_cnt, 2);
    chk8("read_rdata0", rdata_log[0], 8'hA5);
    chk8("read_rdata1", rdata_log[1], 8'h5A);

    // write with a 20-cycle stall before the second data byte
    wv_pct = 100;
    stall_idx = (widx + 1) % 4096;
    stall_left = 20;
    run_txn(8'h02, 1'b0, 24'h0, 8'd3, 8'd0);
    chki("stall_wready_pulses", wr_pulses, 3);
    chki("stall_bytes", mosi_log.size(), 4);
    chki("stall_applied", stall_left, 0);
    chki("stall_cs_low_on_strobe", bad_cs, 0);

    // start held high while busy and during the done cycle
    clear_logs();
    cmd = 8'h06; addr_en = 1'b0; wr_len = 8'd0; rd_len = 8'd0;
    saw_done = 1'b0; start = 1'b1;
    tick();
    cmd = 8'hAA;
    wait_done(500);
    cmd = 8'h04; saw_done = 1'b0;
    tick();
    start = 1'b0;
    wait_done(500);
    chki("restart_bytes", mosi_log.size(), 2);
    chk8("restart_byte0", mosi_log[0], 8'h06);
    chk8("restart_byte1", mosi_log[1], 8'h04);
    chki("restart_done_pulses", done_cnt, 2);

    // reset during the second address byte
    clear_logs();
    cmd = 8'h03; addr_en = 1'b1; addr = 24'hABCDEF; wr_len = 8'd0; rd_len = 8'd1;
    saw_done = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(k == 3 && sl_cnt > 1) && n < 200) begin tick(); n++; end
    chki("reached_addr_byte2", k, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_cs", cs, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_send", m_send, 1'b0);
    chk1("midrst_receive", m_receive, 1'b0);
    run_txn(8'h05, 1'b0, 24'h0, 8'd0, 8'd1);
    chki("postrst_bytes", mosi_log.size(), 2);
    chki("postrst_done_pulses", done_cnt, 1);

`ifdef SPI_XFER_CTRL_DUMMY_EN
    dummy_len = 4'd1;
    run_txn(8'h0B, 1'b1, 24'h000100, 8'd0, 8'd1);
    chki("dummy_bytes", mosi_log.size(), 6);
    chk8("dummy_fill", mosi_log[4], 8'hFF);
    chki("dummy_rv_cnt", rv_cnt, 1);
`endif

    // randomized transactions with stray start pulses while busy
    for (int t = 0; t < 150; t++) begin
      cmd = 8'($urandom); addr_en = 1'($urandom_range(1)); addr = 24'($urandom);
      wr_len = 8'($urandom_range(4)); rd_len = 8'($urandom_range(4));
`ifdef SPI_XFER_CTRL_DUMMY_EN
      dummy_len = 4'($urandom_range(2));
`endif
      wv_pct = $urandom_range(40, 100);
      saw_done = 1'b0; start = 1'b1;
      tick();
      n = 0;
      while (!saw_done && n < 2000) begin
        start = ($urandom_range(3) == 0);
        cmd = 8'($urandom);
        tick();
        n++;
      end
      chk1("random_txn_completes", saw_done, 1'b1);
      start = 1'b0;
      n = $urandom_range(3);
      for (int g = 0; g < n; g++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
